if_id_fetch_queue: RTL

//  Decoupling instruction queue between the fetch stage (IF) and decode stage (ID).
//  - Buffers {instruction, PC+4} pairs from IF in a small FIFO and presents the oldest pair to ID.
//  - Back-pressures IF when full.
//  - Discards all buffered instructions on a taken branch/jump (flush).
//  - Empty queue presents a NOP bubble to ID.

---
 rtl/if_id_fetch_queue.sv | 84 ++++++++
 1 files changed

// File: rtl/if_id_fetch_queue.sv
// Instruction queue between IF and ID: buffers {instr, PC+4} pairs, presents a NOP bubble when empty.
// Optional macro FQ_STARVE_COUNT_EN builds the ID-starved cycle counter on starve_cnt.
module if_id_fetch_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_instr,
    input  logic [DATA_W-1:0]          in_pcplus4,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_instr,
    output logic [DATA_W-1:0]          out_pcplus4,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic [31:0]                starve_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [DATA_W-1:0] instr_mem [DEPTH];
    logic [DATA_W-1:0] pc_mem    [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push;
    logic              pop;

    assign in_ready  = (count != FULL);
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Head is read combinationally and forced to a NOP bubble when empty
    assign out_instr   = out_valid ? instr_mem[rd_ptr] : '0;
    assign out_pcplus4 = out_valid ? pc_mem[rd_ptr]    : '0;

    // Pointer and occupancy state; flush discards everything, including a same-cycle push
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
        end
    end

    // Entry storage needs no reset; the output gating hides stale contents
    always_ff @(posedge clock) begin
        if (push && !flush && !reset) begin
            instr_mem[wr_ptr] <= in_instr;
            pc_mem[wr_ptr]    <= in_pcplus4;
        end
    end

`ifdef FQ_STARVE_COUNT_EN
    // Counts cycles where ID was ready but got a bubble; survives flushes
    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (out_ready && !out_valid) begin
            starve_cnt <= starve_cnt + 32'd1;
        end
    end
`else
    assign starve_cnt = 32'd0;
`endif

endmodule
